// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode encodings and direction constants for the LED pattern engine
package led_pkg;

   typedef enum logic [1:0] {
      MODE_ROT_L  = 2'b00,
      MODE_ROT_R  = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_e;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/led_pattern_engine_tick_gen.sv
// rtl/led_pattern_engine_tick_gen.sv - speed-selectable prescaler producing one step per tick period
module tick_gen
   import led_pkg::*;
#(
   parameter int PERIOD = 50000000,
   parameter int CNT_W  = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   input  logic [1:0] speed,
   output logic       step
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] limit;
   logic             hit;

   // >= rather than == so dropping to a shorter limit mid-count fires immediately
   assign limit = CNT_W'(PERIOD) >> speed;
   assign hit   = (cnt_q >= (limit - CNT_W'(1)));
   assign step  = en & hit;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = hit ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - WIDTH-bit LED rotator/bouncer with load, enable and speed select
module led_pattern_engine
   import led_pkg::*;
#(
   parameter int               WIDTH  = 8,
   parameter int               PERIOD = 50000000,
   parameter int               CNT_W  = 32,
   parameter logic [WIDTH-1:0] INIT   = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [1:0]       speed,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] led,
   output logic             tick,
   output logic             dir
);

   logic [WIDTH-1:0] led_q;
   logic [WIDTH-1:0] led_d;
   logic             dir_q;
   logic             dir_d;
   logic             tick_q;
   logic             step;

   tick_gen #(
      .PERIOD (PERIOD),
      .CNT_W  (CNT_W)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (load),
      .speed (speed),
      .step  (step)
   );

   always_comb begin
      led_d = led_q;
      dir_d = dir_q;
      case (mode_e'(mode))
         MODE_ROT_L: begin
            led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            dir_d = DIR_LEFT;
         end
         MODE_ROT_R: begin
            led_d = {led_q[0], led_q[WIDTH-1:1]};
            dir_d = DIR_RIGHT;
         end
         MODE_BOUNCE: begin
            // both end LEDs lit means there is nowhere to move, so freeze
            if (!(led_q[WIDTH-1] && led_q[0])) begin
               if (dir_q == DIR_LEFT && led_q[WIDTH-1]) begin
                  dir_d = DIR_RIGHT;
                  led_d = led_q >> 1;
               end else if (dir_q == DIR_RIGHT && led_q[0]) begin
                  dir_d = DIR_LEFT;
                  led_d = led_q << 1;
               end else if (dir_q == DIR_LEFT) begin
                  led_d = led_q << 1;
               end else begin
                  led_d = led_q >> 1;
               end
            end
         end
         default: begin
            led_d = led_q;
            dir_d = dir_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q  <= INIT;
         dir_q  <= DIR_LEFT;
         tick_q <= 1'b0;
      end else if (load) begin
         led_q  <= load_val;
         dir_q  <= DIR_LEFT;
         tick_q <= 1'b0;
      end else begin
         tick_q <= step;
         if (step) begin
            led_q <= led_d;
            dir_q <= dir_d;
         end
      end
   end

   assign led  = led_q;
   assign tick = tick_q;
   assign dir  = dir_q;

endmodule
